// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone memory arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  localparam logic [1:0]  W8  = 2'd0;
  localparam logic [1:0]  W16 = 2'd1;
  localparam logic [1:0]  W32 = 2'd2;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/wb_arb_rr2.sv
// Two-input round-robin picker: on a tie the master that did not win last time is chosen.
module wb_arb_rr2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       any
);

  assign any   = |req;
  assign grant = (&req) ? ~last_grant : req[1];

endmodule

// File: rtl/wb_mem_arbiter.sv
// Round-robin Wishbone classic arbiter sharing one memory slave between two masters.
// Optional WAIT timeout with error completion is enabled by defining WB_ARB_TIMEOUT_EN.
module wb_mem_arbiter
  import wb_arb_pkg::*;
#(
  parameter int AW             = 6,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_cyc,
  input  logic          m1_cyc,
  input  logic          m0_stb,
  input  logic          m1_stb,
  input  logic          m0_we,
  input  logic          m1_we,
  input  logic [1:0]    m0_width,
  input  logic [1:0]    m1_width,
  input  logic [AW-1:0] m0_addr,
  input  logic [AW-1:0] m1_addr,
  input  logic [31:0]   m0_wdata,
  input  logic [31:0]   m1_wdata,
  output logic [31:0]   m0_rdata,
  output logic [31:0]   m1_rdata,
  output logic          m0_ack,
  output logic          m1_ack,
  output logic          m0_err,
  output logic          m1_err,
  output logic          m0_stl,
  output logic          m1_stl,
  output logic          s_cyc,
  output logic          s_stb,
  output logic          s_we,
  output logic [1:0]    s_width,
  output logic [AW-1:0] s_addr,
  output logic [31:0]   s_wdata,
  input  logic [31:0]   s_rdata,
  input  logic          s_ack,
  input  logic          s_stl,
  output arb_state_t    dbg_state
);

  // Handshake: a master request is cyc&stb held until its ack/err pulse; the slave
  // takes the strobe in the ISSUE cycle where s_stl=0 and completes with s_ack in WAIT.

  // The wait counter below is 8 bits wide.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_cfg
    $error("wb_mem_arbiter: TIMEOUT_CYCLES must be in 1..255");
  end

  arb_state_t  state, state_nxt;
  logic        grant, last_grant, pick, any;
  logic [1:0]  req;
  logic        ack_in, active, fin_ack, timeout;
  logic [31:0] rdata_sel;

  assign req = {m1_cyc & m1_stb, m0_cyc & m0_stb};

  // Only a solid 1 completes a transfer; floating or unknown ack reads as 0.
  assign ack_in = (s_ack === 1'b1);

  wb_arb_rr2 u_rr (
    .req        (req),
    .last_grant (last_grant),
    .grant      (pick),
    .any        (any)
  );

`ifdef WB_ARB_TIMEOUT_EN
  logic [7:0] wait_cnt;

  assign timeout = (state == WAIT) && !ack_in && (wait_cnt == 8'(TIMEOUT_CYCLES));

  // Held at zero during ISSUE so each WAIT phase starts counting from 0.
  always_ff @(posedge clk) begin
    if (reset || state != WAIT) wait_cnt <= '0;
    else                        wait_cnt <= wait_cnt + 8'd1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any) begin
        grant      <= pick;
        last_grant <= pick;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    s_cyc     = 1'b0;
    s_stb     = 1'b0;
    case (state)
      IDLE:  if (any) state_nxt = ISSUE;
      ISSUE: begin
        s_cyc = 1'b1;
        s_stb = 1'b1;
        if (!s_stl) state_nxt = WAIT;
      end
      WAIT: begin
        s_cyc = 1'b1;
        if (ack_in || timeout) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign active    = (state == ISSUE) || (state == WAIT);
  assign fin_ack   = (state == WAIT) && ack_in;
  assign rdata_sel = timeout ? TIMEOUT_DATA : s_rdata;

  assign s_we    = active & (grant ? m1_we : m0_we);
  assign s_width = active ? (grant ? m1_width : m0_width) : 2'd0;
  assign s_addr  = active ? (grant ? m1_addr  : m0_addr)  : '0;
  assign s_wdata = active ? (grant ? m1_wdata : m0_wdata) : 32'd0;

  assign m0_rdata = (active && !grant) ? rdata_sel : 32'd0;
  assign m1_rdata = (active &&  grant) ? rdata_sel : 32'd0;

  // Completions are gated with the live request so a master that dropped stb sees nothing.
  assign m0_ack = fin_ack & ~grant & req[0];
  assign m1_ack = fin_ack &  grant & req[1];
  assign m0_err = timeout & ~grant & req[0];
  assign m1_err = timeout &  grant & req[1];

  assign m0_stl = !((state == ISSUE) && !grant && !s_stl);
  assign m1_stl = !((state == ISSUE) &&  grant && !s_stl);

  assign dbg_state = state;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed scoreboard bench for wb_mem_arbiter with a byte-addressed slave memory model.
module tb_wb_mem_arbiter;
  import wb_arb_pkg::*;

  localparam int AW = 6;

  logic          clk, reset;
  logic          m0_cyc, m1_cyc, m0_stb, m1_stb, m0_we, m1_we;
  logic [1:0]    m0_width, m1_width;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [31:0]   m0_wdata, m1_wdata, m0_rdata, m1_rdata;
  logic          m0_ack, m1_ack, m0_err, m1_err, m0_stl, m1_stl;
  logic          s_cyc, s_stb, s_we, s_ack, s_stl;
  logic [1:0]    s_width;
  logic [AW-1:0] s_addr;
  logic [31:0]   s_wdata, s_rdata;
  arb_state_t    dbg_state;

  int errors = 0;
  int checks = 0;

  // {check_data, master, data}
  logic [33:0] exp_q[$];

  wb_mem_arbiter #(.AW(AW), .TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .reset(reset),
    .m0_cyc(m0_cyc), .m1_cyc(m1_cyc), .m0_stb(m0_stb), .m1_stb(m1_stb),
    .m0_we(m0_we), .m1_we(m1_we), .m0_width(m0_width), .m1_width(m1_width),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata), .m0_ack(m0_ack), .m1_ack(m1_ack),
    .m0_err(m0_err), .m1_err(m1_err), .m0_stl(m0_stl), .m1_stl(m1_stl),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_width(s_width),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata), .s_ack(s_ack),
    .s_stl(s_stl), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- slave memory model ----------------
  logic [7:0] mem [64] = '{default: 8'h00};
  logic       slv_mute = 1'b0;
  int         stall_req = 0;
  int         stall_cnt = 0;

  function automatic int nbytes(input logic [1:0] w);
    return (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [AW-1:0] a, input logic [1:0] w);
    logic [31:0] r;
    logic [AW-1:0] idx;
    r = 32'd0;
    for (int i = 0; i < nbytes(w); i++) begin
      idx = a + AW'(i);
      r[8*i +: 8] = mem[idx];
    end
    return r;
  endfunction

  assign s_stl = s_cyc && s_stb && (stall_cnt < stall_req);

  always @(posedge clk) begin
    s_ack <= 1'b0;
    if (s_cyc && s_stb) begin
      if (stall_cnt < stall_req) begin
        stall_cnt <= stall_cnt + 1;
      end else begin
        stall_cnt <= 0;
        s_ack     <= !slv_mute;
        s_rdata   <= s_we ? 32'd0 : mem_rd(s_addr, s_width);
        if (s_we)
          for (int i = 0; i < nbytes(s_width); i++)
            mem[s_addr + AW'(i)] <= s_wdata[8*i +: 8];
      end
    end
  end

  // ---------------- checking helpers ----------------
  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- scoreboard monitor ----------------
  logic prev_taken = 1'b0;
  logic [33:0] e;

  always @(negedge clk) begin
    if (!reset) begin
      if (s_stb) check("stb_single_cycle", {31'd0, prev_taken}, 32'd0);
      if (m0_ack || m1_ack) begin
        check("one_ack", {31'd0, m0_ack & m1_ack}, 32'd0);
        check("no_err_on_ack", {30'd0, m0_err, m1_err}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_ack", {31'd0, m1_ack}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("ack_master", {31'd0, m1_ack}, {31'd0, e[32]});
          if (e[33]) check("rdata", m1_ack ? m1_rdata : m0_rdata, e[31:0]);
          check("other_rdata_zero", m1_ack ? m0_rdata : m1_rdata, 32'd0);
        end
      end
    end
    prev_taken <= s_stb && !s_stl;
  end

  // ---------------- driver tasks ----------------
  task automatic xfer(input int m, input logic we, input logic [1:0] w,
                      input logic [AW-1:0] a, input logic [31:0] d, output int lat);
    logic got;
    if (m == 0) begin
      m0_cyc = 1; m0_stb = 1; m0_we = we; m0_width = w; m0_addr = a; m0_wdata = d;
    end else begin
      m1_cyc = 1; m1_stb = 1; m1_we = we; m1_width = w; m1_addr = a; m1_wdata = d;
    end
    lat = 0;
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = (m == 0) ? m0_ack : m1_ack;
      if (!got) lat++;
    end
    @(posedge clk); #1;
    if (m == 0) begin m0_cyc = 0; m0_stb = 0; end
    else        begin m1_cyc = 0; m1_stb = 0; end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_s_bus"}, {29'd0, s_cyc, s_stb, s_we}, 32'd0);
    check({tag, "_acks"}, {28'd0, m0_ack, m1_ack, m0_err, m1_err}, 32'd0);
    check({tag, "_stalls"}, {30'd0, m0_stl, m1_stl}, 32'd3);
    check({tag, "_m0_rdata"}, m0_rdata, 32'd0);
    check({tag, "_m1_rdata"}, m1_rdata, 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  // ---------------- stimulus ----------------
  int lat, la, lb, lc, ld;

  initial begin
    reset = 1;
    {m0_cyc, m1_cyc, m0_stb, m1_stb, m0_we, m1_we} = '0;
    m0_width = 0; m1_width = 0; m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1 reset = 0;

    // Uncontended write then read of the same word.
    exp_q.push_back({1'b0, 1'b0, 32'h0});
    xfer(0, 1, W32, 6'd4, 32'h11223344, lat);
    check("lat_m0_write", lat, 2);
    exp_q.push_back({1'b1, 1'b0, 32'h11223344});
    xfer(0, 0, W32, 6'd4, 32'h0, lat);
    check("lat_m0_read", lat, 2);

    // Both masters contending right after reset: m0, m1, m0, m1.
    do_reset();
    exp_q.push_back({1'b0, 1'b0, 32'h0});
    exp_q.push_back({1'b1, 1'b1, 32'h11223344});
    exp_q.push_back({1'b1, 1'b0, 32'hCAFEF00D});
    exp_q.push_back({1'b0, 1'b1, 32'h0});
    fork
      begin
        xfer(0, 1, W32, 6'd8, 32'hCAFEF00D, la);
        xfer(0, 0, W32, 6'd8, 32'h0, lb);
      end
      begin
        xfer(1, 0, W32, 6'd4, 32'h0, lc);
        xfer(1, 1, W16, 6'd12, 32'h0000BEEF, ld);
      end
    join
    check("rr_lat_m0_first", la, 2);
    check("rr_lat_m1_first", lc, 5);
    check("rr_lat_m0_second", lb, 5);
    check("rr_lat_m1_second", ld, 5);
    exp_q.push_back({1'b1, 1'b0, 32'h0000BEEF});
    xfer(0, 0, W16, 6'd12, 32'h0, lat);
    check("lat_halfword_read", lat, 2);

    // m1 byte write lands before m0 halfword read that overlaps it.
    exp_q.push_back({1'b0, 1'b1, 32'h0});
    exp_q.push_back({1'b1, 1'b0, 32'h0000AB00});
    fork
      xfer(1, 1, W8, 6'd3, 32'h000000AB, la);
      begin
        @(posedge clk); #1;
        xfer(0, 0, W16, 6'd2, 32'h0, lb);
      end
    join
    check("lat_m1_byte_write", la, 2);
    check("lat_m0_after_m1", lb, 4);

    // Slave stalls the strobe for two cycles.
    stall_req = 2;
    exp_q.push_back({1'b1, 1'b0, 32'h11223344});
    xfer(0, 0, W32, 6'd4, 32'h0, lat);
    check("lat_stalled", lat, 4);
    stall_req = 0;

    // Reset in WAIT abandons the transfer without any ack.
    slv_mute = 1;
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_width = W32; m0_addr = 6'd4;
    @(negedge clk);
    check("abort_idle_stb", {31'd0, s_stb}, 32'd0);
    @(negedge clk);
    check("abort_issue_stb", {31'd0, s_stb}, 32'd1);
    check("abort_issue_stalls", {30'd0, m0_stl, m1_stl}, 32'd1);
    @(posedge clk); #1 reset = 1;
    @(negedge clk);
    check("abort_wait_state", 32'(dbg_state), 32'(WAIT));
    check("abort_no_ack", {31'd0, m0_ack}, 32'd0);
    @(posedge clk); #1;
    reset = 0; m0_cyc = 0; m0_stb = 0; slv_mute = 0;
    @(negedge clk);
    check_idle_outputs("after_abort");
    @(posedge clk); #1;
    exp_q.push_back({1'b1, 1'b0, 32'h11223344});
    xfer(0, 0, W32, 6'd4, 32'h0, lat);
    check("lat_after_abort", lat, 2);

    // Slave never acks.
    slv_mute = 1;
    m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_width = W32; m1_addr = 6'd4;
`ifdef WB_ARB_TIMEOUT_EN
    lat = 0;
    for (int i = 0; i < 40 && !m1_err; i++) begin
      @(negedge clk);
      if (!m1_err) lat++;
    end
    check("timeout_lat", lat, 17);
    check("timeout_rdata", m1_rdata, TIMEOUT_DATA);
    @(posedge clk); #1;
    m1_cyc = 0; m1_stb = 0;
    @(negedge clk);
    check("timeout_back_idle", 32'(dbg_state), 32'(IDLE));
`else
    repeat (25) @(negedge clk);
    check("hold_wait_state", 32'(dbg_state), 32'(WAIT));
    check("hold_wait_bus", {30'd0, s_cyc, s_stb}, 32'd2);
    check("hold_no_err", {30'd0, m0_err, m1_err}, 32'd0);
    @(posedge clk); #1;
    m1_cyc = 0; m1_stb = 0;
`endif
    do_reset();
    slv_mute = 0;

    repeat (4) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
